dm_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port data memory `dm` (32-bit words, 64 entries, word-indexed). It serialises load/store requests from the pipeline MEM stage (port 0) and from the test loader/debug port (port 1) onto the one `dm` port. It latches the winning command, drives `dm` for exactly one cycle, and returns registered read data with a valid strobe. It sits between the requesters and `dm`; nothing else drives `dm` inputs.

---
 rtl/dm_arbiter.sv | 130 +++++++++++++
 tb/tb_dm_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory: latches one command, drives dm for one cycle.
// Round-robin by default; define DM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins).
module dm_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] dm_addr,
  output logic          dm_wr,
  output logic          dm_rd,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          id_q, id_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          any_req;
  logic          win;

  assign any_req = req0 | req1;

`ifdef DM_ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  logic last_q, last_d;
  // On a tie the port that did not win last time goes next.
  assign win    = (req0 & req1) ? ~last_q : req1;
  assign last_d = (state_q == IDLE && any_req) ? win : last_q;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      id_q      <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifndef DM_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      id_q      <= id_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifndef DM_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin : outputs
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    dm_wr = 1'b0;
    if (state_q == ACCESS && !rst) begin
      gnt0  = ~id_q;
      gnt1  = id_q;
      dm_wr = we_q;
    end
  end

  always_comb begin : datapath
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    id_d    = id_q;
    if (state_q == IDLE && any_req) begin
      id_d    = win;
      we_d    = win ? we1 : we0;
      addr_d  = win ? addr1 : addr0;
      wdata_d = win ? wdata1 : wdata0;
    end
    rvalid0_d = gnt0 & ~we_q;
    rvalid1_d = gnt1 & ~we_q;
    rdata0_d  = rvalid0_d ? dm_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? dm_rdata : rdata1_q;
  end

  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  assign dm_rd    = 1'b0;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a transaction-level model predicts grant order, timing and read data.
// Build with DM_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_dm_arbiter;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    int          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
  } gnt_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

`ifdef DM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_wr, dm_rd;

  dm_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .dm_addr(dm_addr), .dm_wr(dm_wr), .dm_rd(dm_rd),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: 64 words, combinational read, write at the clock edge.
  logic [31:0] mem [64];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (dm_wr) begin
      mem[dm_addr[5:0]] <= dm_wdata;
    end
  end
  assign dm_rdata = mem[dm_addr[5:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and reference state
  gnt_t        exp_gnt[$];
  rd_t         exp_rd0[$], exp_rd1[$];
  op_t         drv0[$], drv1[$];
  logic [31:0] ref_mem [64];
  int          last_m;
  int          to_cnt = 0;
  int          n_checks = 0, n_pass = 0;
  bit          end_req = 1'b0, end_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every cycle against what the stimulus side predicted.
  initial begin : monitor
    bit   rst_seen;
    gnt_t g;
    rd_t  r;
    rst_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && rst_seen) begin
        check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
      end
      rst_seen = rst;
      check("dm_rd", 32'(dm_rd), 32'd0);
      if (gnt0 || gnt1) begin
        if (exp_gnt.size() == 0) begin
          check("gnt_unexpected", 32'({gnt1, gnt0}), 32'd0);
        end else begin
          g = exp_gnt.pop_front();
          check("gnt0", 32'(gnt0), 32'(g.id == 0));
          check("gnt1", 32'(gnt1), 32'(g.id == 1));
          check("gnt_cycle", cyc, g.due);
          check("dm_wr", 32'(dm_wr), 32'(g.we));
          check("dm_addr", dm_addr, g.addr);
          if (g.we) check("dm_wdata", dm_wdata, g.wdata);
        end
      end else begin
        check("dm_wr_idle", 32'(dm_wr), 32'd0);
      end
      if (rvalid0) begin
        if (exp_rd0.size() == 0) check("rvalid0_unexpected", 32'(rvalid0), 32'd0);
        else begin
          r = exp_rd0.pop_front();
          check("rdata0", rdata0, r.data);
          check("rvalid0_cycle", cyc, r.due);
        end
      end
      if (rvalid1) begin
        if (exp_rd1.size() == 0) check("rvalid1_unexpected", 32'(rvalid1), 32'd0);
        else begin
          r = exp_rd1.pop_front();
          check("rdata1", rdata1, r.data);
          check("rvalid1_cycle", cyc, r.due);
        end
      end
      if (end_req && !end_ack) begin
        check("gnt_left", 32'(exp_gnt.size()), 32'd0);
        check("rd0_left", 32'(exp_rd0.size()), 32'd0);
        check("rd1_left", 32'(exp_rd1.size()), 32'd0);
        check("grant_timeout", 32'(to_cnt), 32'd0);
        end_ack = 1'b1;
      end
    end
  end

  // Reference model: one grant every two cycles, winner chosen by the arbitration rule.
  task automatic plan_round(input int c0);
    op_t  a[$];
    op_t  b[$];
    op_t  op;
    gnt_t g;
    rd_t  r;
    int   t, w;
    a = drv0;
    b = drv1;
    t = c0 + 1;
    while (a.size() + b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) w = FIXED ? 0 : (last_m == 0 ? 1 : 0);
      else w = (a.size() > 0) ? 0 : 1;
      op = (w == 0) ? a.pop_front() : b.pop_front();
      g = '{w, op.we, op.addr, op.wdata, t};
      exp_gnt.push_back(g);
      if (op.we) ref_mem[op.addr[5:0]] = op.wdata;
      else begin
        r = '{ref_mem[op.addr[5:0]], t + 1};
        if (w == 0) exp_rd0.push_back(r); else exp_rd1.push_back(r);
      end
      last_m = w;
      t += 2;
    end
  endtask

  task automatic set_cmd(input int p, input op_t o);
    if (p == 0) begin req0 = 1'b1; we0 = o.we; addr0 = o.addr; wdata0 = o.wdata; end
    else        begin req1 = 1'b1; we1 = o.we; addr1 = o.addr; wdata1 = o.wdata; end
  endtask

  // Called at a negedge with the bus idle; drives drv0/drv1 until every op is granted.
  task automatic run_round();
    int k;
    plan_round(cyc);
    if (drv0.size() > 0) set_cmd(0, drv0[0]);
    if (drv1.size() > 0) set_cmd(1, drv1[0]);
    k = 0;
    while ((req0 || req1) && k < 60) begin
      @(negedge clk);
      k++;
      if (gnt0 && req0) begin
        void'(drv0.pop_front());
        if (drv0.size() > 0) set_cmd(0, drv0[0]); else req0 = 1'b0;
      end
      if (gnt1 && req1) begin
        void'(drv1.pop_front());
        if (drv1.size() > 0) set_cmd(1, drv1[0]); else req1 = 1'b0;
      end
    end
    if (req0 || req1) begin
      to_cnt++;
      req0 = 1'b0;
      req1 = 1'b0;
      drv0.delete();
      drv1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic op_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    op_t o;
    o.we = we; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  initial begin : stimulus
    int n0, n1, k;
    rst = 1'b1; mem_clr = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    last_m = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;

    // Single write, then read back from the other port
    drv0.push_back(mk(1'b1, 32'd5, 32'hDEADBEEF));
    run_round();
    drv1.push_back(mk(1'b0, 32'd5, 32'h0));
    run_round();

    // Preload, then both ports reading continuously must alternate
    drv1.push_back(mk(1'b1, 32'd1, 32'd11));
    drv1.push_back(mk(1'b1, 32'd2, 32'd22));
    run_round();
    for (int i = 0; i < 3; i++) begin
      drv0.push_back(mk(1'b0, 32'd1, 32'h0));
      drv1.push_back(mk(1'b0, 32'd2, 32'h0));
    end
    run_round();

    // Reset lands in the ACCESS cycle of a write: nothing may reach memory or be reported
    set_cmd(0, mk(1'b1, 32'd7, 32'h1234));
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0 = 1'b0;
    last_m = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drv1.push_back(mk(1'b0, 32'd7, 32'h0));
    run_round();

    // Back-to-back write then read from one port
    drv0.push_back(mk(1'b1, 32'd3, 32'hA5A5A5A5));
    drv0.push_back(mk(1'b0, 32'd3, 32'h0));
    run_round();

    // Idle bus
    repeat (10) @(negedge clk);

    // Random mixed traffic with upper address bits that dm must ignore
    for (int r = 0; r < 40; r++) begin
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++)
        drv0.push_back(mk(1'($urandom_range(0, 1)),
                          ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7)), $urandom()));
      for (int i = 0; i < n1; i++)
        drv1.push_back(mk(1'($urandom_range(0, 1)),
                          ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7)), $urandom()));
      run_round();
    end

    end_req = 1'b1;
    k = 0;
    while (!end_ack && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!end_ack) begin
      $display("FAIL monitor_end: got no final check within 10 cycles");
      $fatal(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
